// File: rtl/dm_arb_pkg.sv
// Shared types and sizes for the two-port data-memory arbiter.
package dm_arb_pkg;

   localparam int ADDR_W           = 12;
   localparam int DATA_W           = 16;
   localparam int DM_DEPTH_DEFAULT = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arbState_t;

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester handshakes plus data-memory port of the arbiter.
// master = requesters/memory side, slave = arbiter side.
interface dm_arbiter_if;
   import dm_arb_pkg::*;

   logic              req0, req1;
   logic              we0, we1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              gnt0, gnt1;
   logic              done0, done1;
   logic [DATA_W-1:0] rdata0, rdata1;
   logic              err0, err1;
   logic              we_DM;
   logic [ADDR_W-1:0] addDM;
   logic [DATA_W-1:0] dataDM;
   logic [DATA_W-1:0] outDM;

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, outDM,
      input  gnt0, gnt1, done0, done1, rdata0, rdata1, err0, err1,
      input  we_DM, addDM, dataDM
   );

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, outDM,
      output gnt0, gnt1, done0, done1, rdata0, rdata1, err0, err1,
      output we_DM, addDM, dataDM
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a tie goes to the port not granted last,
// a lone request always wins.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       lastGrant,
   output logic [1:0] grant
);

   always_comb begin
      grant = req;
      if (&req) grant = lastGrant ? 2'b01 : 2'b10;
   end

endmodule

// File: rtl/dm_arbiter.sv
// Two-requester data-memory arbiter, one transaction per three cycles.
// Optional address range check enabled by defining DM_ARB_ADDR_CHK_EN.
//
// state  | meaning
// IDLE   | arbitrate; gnt asserted combinationally, request latched on the edge
// ACCESS | latched address/data driven to memory, write strobe if a write
// RESP   | done pulse to the winner, read data taken from outDM
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int DM_DEPTH = DM_DEPTH_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   dm_arbiter_if.slave   bus
);

   arbState_t         state, nextState;
   logic [1:0]        grant;
   logic              lastGrant;
   logic              arbEn;
   logic              latWe;
   logic              latId;
   logic [ADDR_W-1:0] latAddr;
   logic [DATA_W-1:0] latWdata;
   logic              addrInRange;
   logic              addrOk;

   rr_arb2 uRrArb2 (
      .req       ({bus.req1, bus.req0}),
      .lastGrant (lastGrant),
      .grant     (grant)
   );

   assign arbEn       = (state == IDLE) && !rst;
   assign addrInRange = {20'd0, latAddr} < 32'(DM_DEPTH);

`ifdef DM_ARB_ADDR_CHK_EN
   assign addrOk = addrInRange;
`else
   assign addrOk = 1'b1 | addrInRange;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (bus.req0 || bus.req1) nextState = ACCESS;
         ACCESS:  nextState = RESP;
         RESP:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // lastGrant resets to 1 so the first tie goes to port 0
   always_ff @(posedge clk) begin
      if (rst) begin
         lastGrant <= 1'b1;
         latId     <= 1'b0;
         latWe     <= 1'b0;
         latAddr   <= '0;
         latWdata  <= '0;
      end else if (arbEn && (grant != 2'b00)) begin
         lastGrant <= grant[1];
         latId     <= grant[1];
         latWe     <= grant[1] ? bus.we1    : bus.we0;
         latAddr   <= grant[1] ? bus.addr1  : bus.addr0;
         latWdata  <= grant[1] ? bus.wdata1 : bus.wdata0;
      end
   end

   // addDM/dataDM follow the latches, which only move on a grant and so hold
   // the last ACCESS values everywhere else
   always_comb begin
      bus.gnt0   = arbEn & grant[0];
      bus.gnt1   = arbEn & grant[1];
      bus.we_DM  = (state == ACCESS) & latWe & addrOk & !rst;
      bus.addDM  = latAddr;
      bus.dataDM = latWdata;
      bus.done0  = 1'b0;
      bus.done1  = 1'b0;
      bus.rdata0 = '0;
      bus.rdata1 = '0;
      bus.err0   = 1'b0;
      bus.err1   = 1'b0;
      if ((state == RESP) && !rst) begin
         if (latId) begin
            bus.done1  = 1'b1;
            bus.rdata1 = (!latWe && addrOk) ? bus.outDM : '0;
            bus.err1   = !addrOk;
         end else begin
            bus.done0  = 1'b1;
            bus.rdata0 = (!latWe && addrOk) ? bus.outDM : '0;
            bus.err0   = !addrOk;
         end
      end
   end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus random traffic
// compared against a transaction-level reference model.
module tb_dm_arbiter;

   logic clk = 1'b0;
   logic rst;
   logic memClr;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   dm_arbiter_if bus ();

   dm_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // registered-read data memory, read-before-write
   logic [15:0] mem [0:4095];
   always @(posedge clk) begin
      if (memClr) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 16'h0000;
      end else if (bus.we_DM) begin
         mem[bus.addDM] <= bus.dataDM;
      end
      bus.outDM <= mem[bus.addDM];
   end

`ifdef DM_ARB_ADDR_CHK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
      bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1;
      step();
      step();
      rst = 0;
   endtask

   task automatic test_reset();
      rst = 1; memClr = 1;
      bus.req0 = 1; bus.req1 = 1; bus.we0 = 1; bus.we1 = 1;
      bus.addr0 = 12'h003; bus.addr1 = 12'h004;
      bus.wdata0 = 16'h1234; bus.wdata1 = 16'h5678;
      step();
      step();
      memClr = 0;
      @(negedge clk);
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.we_DM} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: gnt/done/we=%b expected 00000",
                  {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.we_DM});
      end
      checks++;
      if (bus.addDM !== 12'h000 || bus.dataDM !== 16'h0000) begin
         errors++;
         $display("FAIL reset_bus: addDM=%h dataDM=%h expected 0", bus.addDM, bus.dataDM);
      end
      checks++;
      if ({bus.rdata0, bus.rdata1, bus.err0, bus.err1} !== 34'b0) begin
         errors++;
         $display("FAIL reset_resp: rdata0=%h rdata1=%h err=%b%b expected 0",
                  bus.rdata0, bus.rdata1, bus.err0, bus.err1);
      end
      clear_inputs();
      step();
      rst = 0;
   endtask

   task automatic test_write_read();
      do_reset();
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 12'd5; bus.wdata0 = 16'hBEEF;
      @(negedge clk);
      checks++;
      if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
         errors++;
         $display("FAIL wr_gnt: gnt0=%b gnt1=%b expected 1 0", bus.gnt0, bus.gnt1);
      end
      step();
      bus.req0 = 0;
      @(negedge clk);
      checks++;
      if (bus.we_DM !== 1'b1 || bus.addDM !== 12'd5 || bus.dataDM !== 16'hBEEF) begin
         errors++;
         $display("FAIL wr_access: we_DM=%b addDM=%h dataDM=%h expected 1 005 beef",
                  bus.we_DM, bus.addDM, bus.dataDM);
      end
      step();
      @(negedge clk);
      checks++;
      if (bus.done0 !== 1'b1 || bus.done1 !== 1'b0 || bus.err0 !== 1'b0 || bus.rdata0 !== 16'h0) begin
         errors++;
         $display("FAIL wr_done: done0=%b done1=%b err0=%b rdata0=%h expected 1 0 0 0000",
                  bus.done0, bus.done1, bus.err0, bus.rdata0);
      end
      step();
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 12'd5;
      @(negedge clk);
      checks++;
      if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin
         errors++;
         $display("FAIL rd_gnt: gnt0=%b gnt1=%b expected 0 1", bus.gnt0, bus.gnt1);
      end
      step();
      bus.req1 = 0;
      @(negedge clk);
      checks++;
      if (bus.we_DM !== 1'b0 || bus.addDM !== 12'd5) begin
         errors++;
         $display("FAIL rd_access: we_DM=%b addDM=%h expected 0 005", bus.we_DM, bus.addDM);
      end
      step();
      @(negedge clk);
      checks++;
      if (bus.done1 !== 1'b1 || bus.rdata1 !== 16'hBEEF || bus.done0 !== 1'b0) begin
         errors++;
         $display("FAIL rd_done: done1=%b rdata1=%h done0=%b expected 1 beef 0",
                  bus.done1, bus.rdata1, bus.done0);
      end
      step();
   endtask

   task automatic test_tie();
      do_reset();
      bus.req0 = 1; bus.req1 = 1; bus.addr0 = 12'd0; bus.addr1 = 12'd1;
      for (int c = 0; c < 12; c++) begin
         logic [3:0] exp;
         @(negedge clk);
         exp[3] = (c % 3 == 0) && ((c / 3) % 2 == 0);
         exp[2] = (c % 3 == 0) && ((c / 3) % 2 == 1);
         exp[1] = (c % 3 == 2) && ((c / 3) % 2 == 0);
         exp[0] = (c % 3 == 2) && ((c / 3) % 2 == 1);
         checks++;
         if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1} !== exp) begin
            errors++;
            $display("FAIL tie_cycle%0d: gnt0,gnt1,done0,done1=%b expected %b",
                     c, {bus.gnt0, bus.gnt1, bus.done0, bus.done1}, exp);
         end
         step();
      end
      clear_inputs();
      step();
   endtask

   task automatic test_lone_req1();
      do_reset();
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 12'd5;
      @(negedge clk);
      checks++;
      if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin
         errors++;
         $display("FAIL lone_gnt1: gnt0=%b gnt1=%b expected 0 1", bus.gnt0, bus.gnt1);
      end
      step();
      bus.req1 = 0;
      step();
      @(negedge clk);
      checks++;
      if (bus.done1 !== 1'b1 || bus.rdata1 !== 16'hBEEF) begin
         errors++;
         $display("FAIL lone_done: done1=%b rdata1=%h expected 1 beef", bus.done1, bus.rdata1);
      end
      step();
   endtask

   task automatic test_reset_abort();
      do_reset();
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 12'd7; bus.wdata0 = 16'h1111;
      step();
      bus.req0 = 0;
      step();
      step();
      bus.req0 = 1; bus.wdata0 = 16'h2222;
      @(negedge clk);
      checks++;
      if (bus.gnt0 !== 1'b1) begin
         errors++;
         $display("FAIL abort_gnt: gnt0=%b expected 1", bus.gnt0);
      end
      step();
      bus.req0 = 0;
      rst = 1;
      @(negedge clk);
      checks++;
      if (bus.we_DM !== 1'b0) begin
         errors++;
         $display("FAIL abort_we: we_DM=%b expected 0", bus.we_DM);
      end
      step();
      rst = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (bus.done0 !== 1'b0 || bus.done1 !== 1'b0) begin
            errors++;
            $display("FAIL abort_nodone%0d: done0=%b done1=%b expected 0 0",
                     c, bus.done0, bus.done1);
         end
         step();
      end
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 12'd7;
      step();
      bus.req1 = 0;
      step();
      @(negedge clk);
      checks++;
      if (bus.done1 !== 1'b1 || bus.rdata1 !== 16'h1111) begin
         errors++;
         $display("FAIL abort_read: done1=%b rdata1=%h expected 1 1111", bus.done1, bus.rdata1);
      end
      step();
   endtask

   task automatic test_addr_check();
      logic [15:0] expRd;
      do_reset();
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 12'd40; bus.wdata0 = 16'h5555;
      step();
      bus.req0 = 0;
      @(negedge clk);
      checks++;
      if (bus.we_DM !== !CHK_EN || bus.addDM !== 12'd40) begin
         errors++;
         $display("FAIL oor_we: we_DM=%b addDM=%h expected %b 028", bus.we_DM, bus.addDM, !CHK_EN);
      end
      step();
      @(negedge clk);
      checks++;
      if (bus.done0 !== 1'b1 || bus.err0 !== CHK_EN || bus.rdata0 !== 16'h0) begin
         errors++;
         $display("FAIL oor_wdone: done0=%b err0=%b rdata0=%h expected 1 %b 0000",
                  bus.done0, bus.err0, bus.rdata0, CHK_EN);
      end
      step();
      bus.req0 = 1; bus.we0 = 0;
      step();
      bus.req0 = 0;
      step();
      @(negedge clk);
      expRd = CHK_EN ? 16'h0000 : 16'h5555;
      checks++;
      if (bus.done0 !== 1'b1 || bus.err0 !== CHK_EN || bus.rdata0 !== expRd) begin
         errors++;
         $display("FAIL oor_rdone: done0=%b err0=%b rdata0=%h expected 1 %b %h",
                  bus.done0, bus.err0, bus.rdata0, CHK_EN, expRd);
      end
      step();
   endtask

   // Model: a grant at cycle g drives memory at g+1, answers at g+2 and frees
   // the arbiter for g+3; ties go to the port that lost the previous grant.
   task automatic test_random();
      logic [15:0] memModel [0:63];
      logic        pend [2];
      logic        pWe [2];
      logic [11:0] pAddr [2];
      logic [15:0] pData [2];
      int          freeAt, accAt, doneAt, tId, win;
      logic        favor, tWe, tOk;
      logic [11:0] tAddr;
      logic [15:0] tData, tRd;
      logic [1:0]  eG;
      logic        eD0, eD1, eWe;

      memClr = 1;
      step();
      memClr = 0;
      for (int i = 0; i < 64; i++) memModel[i] = 16'h0000;
      do_reset();
      for (int p = 0; p < 2; p++) begin
         pend[p] = 0; pWe[p] = 0; pAddr[p] = '0; pData[p] = '0;
      end
      freeAt = 0; accAt = -1; doneAt = -1; tId = 0;
      favor = 0; tWe = 0; tOk = 1; tAddr = '0; tData = '0; tRd = '0;

      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && $urandom_range(0, 2) != 0) begin
               pend[p]  = 1;
               pWe[p]   = 1'($urandom_range(0, 1));
               pAddr[p] = 12'($urandom_range(0, 63));
               pData[p] = 16'($urandom);
            end
         end
         bus.req0 = pend[0]; bus.we0 = pWe[0]; bus.addr0 = pAddr[0]; bus.wdata0 = pData[0];
         bus.req1 = pend[1]; bus.we1 = pWe[1]; bus.addr1 = pAddr[1]; bus.wdata1 = pData[1];
         @(negedge clk);

         eG = 2'b00;
         if (cyc >= freeAt && (pend[0] || pend[1])) begin
            win = (pend[0] && pend[1]) ? int'(favor) : (pend[1] ? 1 : 0);
            eG[win] = 1'b1;
            favor = (win == 0);
            tId = win; tWe = pWe[win]; tAddr = pAddr[win]; tData = pData[win];
            tOk = !CHK_EN || (pAddr[win] < 12'd32);
            tRd = (!tWe && tOk) ? memModel[tAddr[5:0]] : 16'h0000;
            if (tWe && tOk) memModel[tAddr[5:0]] = tData;
            pend[win] = 0;
            accAt = cyc + 1; doneAt = cyc + 2; freeAt = cyc + 3;
         end
         checks++;
         if ({bus.gnt1, bus.gnt0} !== eG) begin
            errors++;
            $display("FAIL rnd_gnt c%0d: gnt1,gnt0=%b expected %b", cyc, {bus.gnt1, bus.gnt0}, eG);
         end

         eWe = (cyc == accAt) && tWe && tOk;
         checks++;
         if (bus.we_DM !== eWe) begin
            errors++;
            $display("FAIL rnd_we c%0d: we_DM=%b expected %b", cyc, bus.we_DM, eWe);
         end
         if (cyc == accAt) begin
            checks++;
            if (bus.addDM !== tAddr || bus.dataDM !== tData) begin
               errors++;
               $display("FAIL rnd_bus c%0d: addDM=%h dataDM=%h expected %h %h",
                        cyc, bus.addDM, bus.dataDM, tAddr, tData);
            end
         end

         eD0 = (cyc == doneAt) && (tId == 0);
         eD1 = (cyc == doneAt) && (tId == 1);
         checks++;
         if (bus.done0 !== eD0 || bus.done1 !== eD1
             || bus.rdata0 !== (eD0 ? tRd : 16'h0) || bus.rdata1 !== (eD1 ? tRd : 16'h0)
             || bus.err0 !== (eD0 && !tOk) || bus.err1 !== (eD1 && !tOk)) begin
            errors++;
            $display("FAIL rnd_resp c%0d: done=%b%b rdata0=%h rdata1=%h err=%b%b expected done=%b%b rdata=%h err=%b",
                     cyc, bus.done0, bus.done1, bus.rdata0, bus.rdata1, bus.err0, bus.err1,
                     eD0, eD1, tRd, !tOk);
         end
         step();
      end
      clear_inputs();
      step();
      step();
      step();
   endtask

   initial begin
      rst = 1;
      memClr = 0;
      clear_inputs();
      test_reset();
      test_write_read();
      test_tie();
      test_lone_req1();
      test_reset_abort();
      test_addr_check();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter DM_DEPTH, default 32: number of valid data-memory words; used only by the address check.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset is synchronous and active-high.
REQ-004 reqN (N=0,1)  input  1  requester N access request; held until gntN.
REQ-005 weN  input  1  requester N: 1 = write, 0 = read; stable while reqN=1.
REQ-006 addrN  input  12  requester N word address; stable while reqN=1.
REQ-007 wdataN  input  16  requester N write data; stable while reqN=1.
REQ-008 gntN  output  1  request N accepted this cycle.
REQ-009 doneN  output  1  one-cycle completion pulse for requester N.
REQ-010 rdataN  output  16  read data, valid while doneN=1.
REQ-011 errN  output  1  address-error flag, valid while doneN=1.
REQ-012 we_DM  output  1  write enable to the data memory.
REQ-013 addDM  output  12  address to the data memory.
REQ-014 dataDM  output  16  write data to the data memory.
REQ-015 outDM  input  16  registered read data from the data memory, valid one edge after the address is presented with we_DM=0.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCESS and RESP.
- IDLE->ACCESS on any reqN.
- ACCESS->RESP unconditionally.
- RESP->IDLE unconditionally.
REQ-017 In IDLE, gntN SHALL assert combinationally for exactly one requester with reqN=1.
- On that edge, weN, addrN, wdataN and the winner ID are latched.
- gnt is never asserted outside IDLE.
REQ-018 When both requests are asserted, the arbiter SHALL grant the port not granted last (round robin); after reset, port 0 wins the first tie.
REQ-019 A lone request SHALL be granted regardless of the round-robin pointer.
REQ-020 The pointer SHALL update only on a grant.
REQ-021 In ACCESS, addDM and dataDM SHALL carry the latched values, and we_DM = latched we AND NOT rst.
REQ-022 Outside ACCESS:
- we_DM SHALL be 0.
- addDM and dataDM SHALL hold their last values.
REQ-023 In RESP, done of the latched winner SHALL pulse:
- rdata = outDM for reads, 0 for writes.
- The other port's done, rdata and err stay 0.
REQ-024 Timing and throughput:
- Latency from the grant edge to done SHALL be 2 cycles.
- Sustained throughput SHALL be one transaction per 3 cycles.
- A request held high after done is re-arbitrated in the following IDLE cycle.

Reset
REQ-025 While rst=1, the FSM SHALL enter IDLE and the pointer SHALL favour port 0.
REQ-026 All outputs SHALL be 0 after the reset edge, including gnt, done, rdata, err, we_DM, addDM and dataDM.
REQ-027 Reset asserted during ACCESS SHALL suppress the pending memory write, because we_DM is gated by rst.
REQ-028 A transaction aborted by reset SHALL produce no done pulse.

Configuration
REQ-029 With DM_ARB_ADDR_CHK_EN defined, a latched address >= DM_DEPTH SHALL:
- hold we_DM at 0 in ACCESS;
- return err=1 and rdata=0 with done.
REQ-030 Without DM_ARB_ADDR_CHK_EN, err0 and err1 SHALL be tied 0 and every address SHALL be forwarded unchanged.

Structure
REQ-031 Package dm_arb_pkg SHALL hold:
- the state enum (IDLE, ACCESS, RESP);
- ADDR_W=12 and DATA_W=16;
- the default DM_DEPTH=32.
REQ-032 The two-way round-robin pick SHALL be a sub-module rr_arb2 with inputs req[1:0] and the last-grant bit, and a one-hot grant[1:0] output.

Verification
REQ-033 The bench SHALL cover a port 0 write of addr 5, data 0xBEEF: gnt0 in cycle 0, we_DM=1 with addDM=5 in cycle 1, done0 in cycle 2; a later port 1 read of addr 5 returns rdata1=0xBEEF.
REQ-034 The bench SHALL cover req0 and req1 held high together after reset: grants alternate 0,1,0,1 and each done follows its grant by 2 cycles.
REQ-035 The bench SHALL cover only req1 with the pointer favouring port 0: gnt1 is asserted immediately.
REQ-036 The bench SHALL cover rst asserted in the ACCESS cycle of a write to addr 7 holding 0x1111 with new data 0x2222: we_DM=0 on that edge, no done, and a later read returns 0x1111.
REQ-037 The bench SHALL cover, with DM_ARB_ADDR_CHK_EN, a port 0 write to addr 40: we_DM stays 0, done0=1 with err0=1 and rdata0=0; without the macro, err0=0.
